// File: rtl/arb_pkg.sv
// Shared types and constants for the aging minimum-priority arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } arb_state_t;

  localparam int         NUM_REQ   = 4;
  localparam logic [2:0] PRI_RESET = 3'b111;
  localparam int         AGE_CNT_W = 4;

endpackage

// File: rtl/masked_min4_select.sv
// Picks the masked entry with the smallest value; ties go to the lowest index.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   vals  : four packed PW-bit values, vals[PW*i +: PW] is entry i
//   mask  : entry i takes part only when mask[i]=1
//   idx   : index of the winning entry (0 when nothing is masked in)
//   vld   : high when at least one entry is masked in
module masked_min4_select #(
  parameter int PW = 3
) (
  input  logic [4*PW-1:0] vals,
  input  logic [3:0]      mask,
  output logic [1:0]      idx,
  output logic            vld
);

  logic [PW-1:0] best_val;

  // Scan upward; a later entry only displaces the running best when it is
  // strictly smaller, which is what gives lowest-index-wins on ties.
  always_comb begin
    best_val = '0;
    idx      = '0;
    vld      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i] && (!vld || (vals[PW*i +: PW] < best_val))) begin
        vld      = 1'b1;
        best_val = vals[PW*i +: PW];
        idx      = 2'(i);
      end
    end
  end

endmodule

// File: rtl/aging_min_arbiter.sv
// Four-way arbiter granting the lowest effective priority; waiting requesters age toward 0.
// Latency: grant registered 1 cycle after req sampled; release costs 1 idle TURN cycle.
// Backpressure: non-owners wait (and age) while BUSY; owner releases via done or by dropping req.
//
// Ports:
//   clk, reset : single clock, synchronous active-high reset
//   req        : per-requester request level
//   pri        : packed static priorities, pri[PW*i +: PW] for requester i
//   done       : owner releases the resource (looked at only in BUSY)
//   gnt        : registered one-hot grant
//   gnt_valid  : high while a grant is held
//   gnt_index  : current owner, holds last owner while gnt_valid=0
module aging_min_arbiter
  import arb_pkg::*;
#(
  parameter int AGE_PERIOD = 8,
  parameter int PW         = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [4*PW-1:0]     pri,
  input  logic                done,
  output logic [NUM_REQ-1:0]  gnt,
  output logic                gnt_valid,
  output logic [1:0]          gnt_index
);

  localparam logic [AGE_CNT_W-1:0] AGE_LAST = AGE_CNT_W'(AGE_PERIOD - 1);

  arb_state_t           state_q, state_d;
  logic [PW-1:0]        eff     [NUM_REQ];
  logic [AGE_CNT_W-1:0] age_cnt [NUM_REQ];
  logic [4*PW-1:0]      eff_flat;

  logic [1:0]           sel;
  logic                 any_req;
  logic                 grant_now;
  logic [NUM_REQ-1:0]   gnt_d;
  logic                 gnt_valid_d;
  logic [1:0]           gnt_index_d;
  logic [NUM_REQ-1:0]   reload_mask;
  logic [NUM_REQ-1:0]   owner_mask;

  always_comb begin
    eff_flat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eff_flat[PW*i +: PW] = eff[i];
    end
  end

  // The selector's valid flag is exactly OR(req), so it doubles as any_req.
  masked_min4_select #(
    .PW (PW)
  ) u_select (
    .vals (eff_flat),
    .mask (req),
    .idx  (sel),
    .vld  (any_req)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt;
    gnt_valid_d = gnt_valid;
    gnt_index_d = gnt_index;
    grant_now   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_now   = 1'b1;
          gnt_d       = NUM_REQ'(1) << sel;
          gnt_index_d = sel;
          gnt_valid_d = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // An owner that drops its request is treated as having finished.
        if (done || !req[gnt_index]) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          state_d     = TURN;
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Requesters restart from their static priority when idle or just granted;
  // the current owner's aging is frozen (gnt is the owner's one-hot in BUSY).
  assign reload_mask = ~req | (grant_now ? gnt_d : '0);
  assign owner_mask  = (state_q == BUSY) ? gnt : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_index <= '0;
    end else begin
      state_q   <= state_d;
      gnt       <= gnt_d;
      gnt_valid <= gnt_valid_d;
      gnt_index <= gnt_index_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        eff[i]     <= PW'(PRI_RESET);
        age_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (reload_mask[i]) begin
          eff[i]     <= pri[PW*i +: PW];
          age_cnt[i] <= '0;
        end else if (!owner_mask[i]) begin
          if (age_cnt[i] == AGE_LAST) begin
            age_cnt[i] <= '0;
            // Saturate at the most urgent level instead of wrapping.
            if (eff[i] != '0) begin
              eff[i] <= eff[i] - 1'b1;
            end
          end else begin
            age_cnt[i] <= age_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_aging_min_arbiter.sv
module tb_aging_min_arbiter;
  import arb_pkg::*;

  localparam int P  = 8;
  localparam int PW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      req;
  logic [4*PW-1:0] pri;
  logic            done;
  logic [3:0]      gnt;
  logic            gnt_valid;
  logic [1:0]      gnt_index;

  aging_min_arbiter #(.AGE_PERIOD(P), .PW(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .pri       (pri),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_index (gnt_index)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: state 0=idle 1=busy 2=turn; effective priority of a
  // requester is its base priority minus one per full AGE period waited.
  int m_state;
  bit m_vld;
  int m_idx;
  int base   [4];
  int waited [4];

  function automatic int m_eff(int i);
    int e;
    e = base[i] - waited[i] / P;
    return (e < 0) ? 0 : e;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int mn;
    int sel;
    int effs [4];
    bit grant;
    if (reset) begin
      m_state = 0; m_vld = 0; m_idx = 0;
      for (int i = 0; i < 4; i++) begin base[i] = 7; waited[i] = 0; end
      return;
    end
    mn = 1000;
    for (int i = 0; i < 4; i++) begin
      effs[i] = m_eff(i);
      if (req[i] && effs[i] < mn) mn = effs[i];
    end
    sel = 0;
    for (int i = 3; i >= 0; i--) if (req[i] && effs[i] == mn) sel = i;
    grant = (m_state == 0) && (req != 4'b0);
    for (int i = 0; i < 4; i++) begin
      if (!req[i] || (grant && sel == i)) begin
        base[i] = int'(pri[PW*i +: PW]); waited[i] = 0;
      end else if (!(m_state == 1 && m_idx == i)) begin
        waited[i]++;
      end
    end
    case (m_state)
      0: if (grant) begin m_vld = 1; m_idx = sel; m_state = 1; end
      1: if (done || !req[m_idx]) begin m_vld = 0; m_state = 2; end
      default: m_state = 0;
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("gnt", int'(gnt), m_vld ? (1 << m_idx) : 0);
    check("gnt_valid", int'(gnt_valid), int'(m_vld));
    check("gnt_index", int'(gnt_index), m_idx);
    check("gnt_invariant", int'($onehot0(gnt) && ((gnt != 4'b0) == gnt_valid)), 1);
    for (int i = 0; i < 4; i++) check($sformatf("eff%0d", i), int'(dut.eff[i]), m_eff(i));
  endtask

  task automatic set_pri(input int i, input int v);
    pri[PW*i +: PW] = PW'(v);
  endtask

  initial begin
    reset = 1'b1; req = 4'b0; pri = '0; done = 1'b0;

    // Reset then idle.
    tick(); tick();
    check("rst_gnt", int'(gnt), 0);
    check("rst_valid", int'(gnt_valid), 0);
    check("rst_index", int'(gnt_index), 0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("idle_gnt", int'(gnt), 0);
    check("idle_valid", int'(gnt_valid), 0);

    // Priority and tie-break: b and c tie at 1, b wins on index.
    set_pri(0, 5); set_pri(1, 1); set_pri(2, 1); set_pri(3, 2);
    tick();
    req = 4'b1111;
    tick();
    check("tie_gnt", int'(gnt), 4'b0010);
    check("tie_index", int'(gnt_index), 1);
    done = 1'b1; req = 4'b1101;
    tick();
    check("release_gnt", int'(gnt), 0);
    done = 1'b0;
    tick();
    check("turn_gap_gnt", int'(gnt), 0);
    tick();
    check("next_gnt", int'(gnt), 4'b0100);
    done = 1'b1; req = 4'b0;
    tick();
    done = 1'b0;
    tick(); tick();

    // Aging: b waits 24 cycles behind a and overtakes c's better static priority.
    set_pri(0, 0); set_pri(1, 3); set_pri(2, 1); set_pri(3, 7);
    tick();
    req = 4'b0001;
    tick();
    check("age_owner_a", int'(gnt), 4'b0001);
    req = 4'b0011;
    for (int k = 0; k < 24; k++) tick();
    check("age_eff_b", int'(dut.eff[1]), 0);
    req = 4'b0110; done = 1'b1;
    tick();
    done = 1'b0;
    tick(); tick();
    check("age_gnt_b", int'(gnt), 4'b0010);
    done = 1'b1; req = 4'b0;
    tick();
    done = 1'b0;
    tick(); tick();

    // Saturation: d waits 40 cycles from pri 2 and must stop at 0.
    set_pri(0, 0); set_pri(3, 2);
    tick();
    req = 4'b0001;
    tick();
    req = 4'b1001;
    for (int k = 0; k < 40; k++) begin
      tick();
      check("sat_no_wrap", int'(dut.eff[3] != 3'd7), 1);
    end
    check("sat_eff_d", int'(dut.eff[3]), 0);

    // Abandonment: a drops req without done.
    req = 4'b1010;
    tick();
    check("abandon_gnt", int'(gnt), 0);
    check("abandon_valid", int'(gnt_valid), 0);
    tick();
    check("abandon_turn", int'(gnt), 0);
    tick();
    check("abandon_next", int'(gnt), 4'b1000);
    check("abandon_index", int'(gnt_index), 3);

    // Reset mid-grant with a simultaneous done.
    reset = 1'b1; done = 1'b1;
    tick();
    check("midrst_gnt", int'(gnt), 0);
    check("midrst_valid", int'(gnt_valid), 0);
    check("midrst_index", int'(gnt_index), 0);
    for (int i = 0; i < 4; i++) check("midrst_eff", int'(dut.eff[i]), 7);
    reset = 1'b0; done = 1'b0;
    tick();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 0) set_pri(i, $urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      end
      done = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
